// File: rtl/keccak_stream_host.sv
// keccak_stream_host
//   Host-side driver for the Keccak sponge core. Fetches a message from a
//   word-addressed source memory, streams it into the core's input-bytes
//   handshake, then writes the squeezed output words to a destination memory
//   and reports completion.
//
//   Optional feature macro: KECCAK_HOST_TIMEOUT_EN
//     defined   : a no-progress watchdog aborts the transaction after
//                 TIMEOUT_CYC stalled cycles (o_error, no o_done).
//     undefined : the block waits indefinitely.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start, i_mode, i_msg_len,   command strobe and transaction parameters
//   i_out_len
//   o_mem_rd/o_mem_addr/i_mem_rdata   source read port (1-cycle read latency)
//   o_dout_we/o_dout_addr/o_dout_data destination write port (registered)
//   o_busy, o_done, o_error       status
//   o_k_mode/o_k_ibytes_len/o_k_obytes_len   core configuration
//   o_k_ibytes/_valid, i_k_ibytes_ready      core input handshake
//   i_k_obytes/_valid, i_k_obytes_done       core output stream
module keccak_stream_host #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [1:0]  i_mode,
    input  logic [10:0] i_msg_len,
    input  logic [9:0]  i_out_len,
    output logic        o_mem_rd,
    output logic [7:0]  o_mem_addr,
    input  logic [63:0] i_mem_rdata,
    output logic        o_dout_we,
    output logic [6:0]  o_dout_addr,
    output logic [63:0] o_dout_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_k_mode,
    output logic [10:0] o_k_ibytes_len,
    output logic [9:0]  o_k_obytes_len,
    output logic [63:0] o_k_ibytes,
    output logic        o_k_ibytes_valid,
    input  logic        i_k_ibytes_ready,
    input  logic [63:0] i_k_obytes,
    input  logic        i_k_obytes_valid,
    input  logic        i_k_obytes_done
);
    typedef enum logic [1:0] {S_IDLE, S_CFG, S_FEED, S_DRAIN} state_t;

    state_t      r_state;
    logic        r_busy, r_done, r_error;
    logic [1:0]  r_k_mode;
    logic [10:0] r_k_ilen;
    logic [9:0]  r_k_olen;
    logic        r_empty;        // zero-length message
    logic [8:0]  r_n_xfer;       // input transfers required (>= 1)
    logic [8:0]  r_fetched;      // reads issued, also the next read address
    logic [8:0]  r_xfer;         // input transfers completed
    logic [63:0] r_fifo [2];
    logic        r_rptr, r_wptr;
    logic [1:0]  r_cnt;          // words held in the FIFO
    logic        r_pend;         // read issued last cycle; data on i_mem_rdata now
    logic        r_dout_we;
    logic [6:0]  r_dout_addr, r_wr_ptr;
    logic [63:0] r_dout_data;

    logic        w_feed, w_rd, w_valid, w_xfer, w_push, w_pop, w_last, w_out_wr;
    logic        w_bad, w_timeout;
    logic [11:0] w_len_rnd;
    logic [8:0]  w_n_in;
    logic [9:0]  w_olen;
    logic [2:0]  w_rem;
    logic [63:0] w_raw, w_mask, w_head;

    assign w_len_rnd = {1'b0, i_msg_len} + 12'd7;
    assign w_n_in    = w_len_rnd[11:3];
    assign w_olen    = (i_mode == 2'b10) ? 10'd32 :
                       (i_mode == 2'b11) ? 10'd64 : i_out_len;
    assign w_bad     = !i_mode[1] && (i_out_len == 10'd0);

    assign w_feed   = (r_state == S_FEED);
    // In-flight reads count against FIFO space so a stalled consumer never
    // overflows the two entries.
    assign w_rd     = w_feed && !r_empty && (r_fetched < r_n_xfer) &&
                      ((r_cnt + {1'b0, r_pend}) < 2'd2);
    // Fall-through: returning read data is presented the cycle it arrives
    // when the FIFO is empty, giving 1 word/cycle with one read in flight.
    assign w_valid  = w_feed && (r_empty || (r_cnt != 2'd0) || r_pend);
    assign w_raw    = (r_cnt != 2'd0) ? r_fifo[r_rptr] : i_mem_rdata;
    assign w_last   = (r_xfer == r_n_xfer - 9'd1);
    assign w_rem    = r_k_ilen[2:0];
    // Byte 0 sits in [63:56]; keep the leading w_rem bytes of the last word.
    assign w_mask   = (w_last && (w_rem != 3'd0)) ?
                      ~(64'hFFFF_FFFF_FFFF_FFFF >> {w_rem, 3'b000}) : '1;
    assign w_head   = r_empty ? '0 : (w_raw & w_mask);
    assign w_xfer   = w_valid && i_k_ibytes_ready;
    assign w_push   = r_pend && !((r_cnt == 2'd0) && w_xfer);
    assign w_pop    = w_xfer && (r_cnt != 2'd0);
    assign w_out_wr = (w_feed || (r_state == S_DRAIN)) && i_k_obytes_valid;

`ifdef KECCAK_HOST_TIMEOUT_EN
    logic [15:0] r_idle;
    logic        w_active, w_prog;

    assign w_active  = w_feed || (r_state == S_DRAIN);
    assign w_prog    = w_feed ? w_xfer : i_k_obytes_valid;
    assign w_timeout = w_active && !w_prog && (r_idle == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_active || w_prog || w_timeout) r_idle <= '0;
        else                                           r_idle <= r_idle + 16'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_k_mode    <= '0;
            r_k_ilen    <= '0;
            r_k_olen    <= '0;
            r_empty     <= 1'b0;
            r_n_xfer    <= '0;
            r_fetched   <= '0;
            r_xfer      <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_rptr      <= 1'b0;
            r_wptr      <= 1'b0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_dout_we   <= 1'b0;
            r_dout_addr <= '0;
            r_wr_ptr    <= '0;
            r_dout_data <= '0;
        end else begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_dout_we <= 1'b0;
            if (w_out_wr) begin
                r_dout_we   <= 1'b1;
                r_dout_data <= i_k_obytes;
                r_dout_addr <= r_wr_ptr;
                r_wr_ptr    <= r_wr_ptr + 7'd1;
            end
            case (r_state)
                S_IDLE: begin
                    // busy lingers one cycle after done/error, then drops
                    r_busy <= 1'b0;
                    if (i_start && !r_busy) begin
                        r_busy <= 1'b1;
                        if (w_bad) begin
                            r_error <= 1'b1;
                        end else begin
                            r_k_mode <= i_mode;
                            r_k_ilen <= i_msg_len;
                            r_k_olen <= w_olen;
                            r_empty  <= (i_msg_len == 11'd0);
                            r_n_xfer <= (i_msg_len == 11'd0) ? 9'd1 : w_n_in;
                            r_state  <= S_CFG;
                        end
                    end
                end
                S_CFG: begin
                    r_fetched <= '0;
                    r_xfer    <= '0;
                    r_cnt     <= '0;
                    r_rptr    <= 1'b0;
                    r_wptr    <= 1'b0;
                    r_pend    <= 1'b0;
                    r_wr_ptr  <= '0;
                    r_state   <= S_FEED;
                end
                S_FEED: begin
                    r_pend <= w_rd;
                    if (w_rd) r_fetched <= r_fetched + 9'd1;
                    if (w_push) begin
                        r_fifo[r_wptr] <= i_mem_rdata;
                        r_wptr         <= ~r_wptr;
                    end
                    if (w_pop) r_rptr <= ~r_rptr;
                    r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
                    if (w_xfer) begin
                        r_xfer <= r_xfer + 9'd1;
                        if (w_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_k_obytes_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_timeout) begin
                r_error <= 1'b1;
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
                r_rptr  <= 1'b0;
                r_wptr  <= 1'b0;
            end
        end
    end

    assign o_mem_rd         = w_rd;
    assign o_mem_addr       = r_fetched[7:0];
    assign o_k_ibytes_valid = w_valid;
    assign o_k_ibytes       = w_valid ? w_head : '0;
    assign o_dout_we        = r_dout_we;
    assign o_dout_addr      = r_dout_addr;
    assign o_dout_data      = r_dout_data;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_error          = r_error;
    assign o_k_mode         = r_k_mode;
    assign o_k_ibytes_len   = r_k_ilen;
    assign o_k_obytes_len   = r_k_olen;
endmodule

// File: tb/tb_keccak_stream_host.sv
// Directed bench for keccak_stream_host: memory model, core stand-in and a
// negedge monitor collecting reads, input transfers and destination writes.
module tb_keccak_stream_host;
    logic        i_clk = 1'b0;
    logic        i_rst, i_start;
    logic [1:0]  i_mode;
    logic [10:0] i_msg_len;
    logic [9:0]  i_out_len;
    logic        o_mem_rd;
    logic [7:0]  o_mem_addr;
    logic [63:0] i_mem_rdata;
    logic        o_dout_we;
    logic [6:0]  o_dout_addr;
    logic [63:0] o_dout_data;
    logic        o_busy, o_done, o_error;
    logic [1:0]  o_k_mode;
    logic [10:0] o_k_ibytes_len;
    logic [9:0]  o_k_obytes_len;
    logic [63:0] o_k_ibytes;
    logic        o_k_ibytes_valid;
    logic        i_k_ibytes_ready;
    logic [63:0] i_k_obytes;
    logic        i_k_obytes_valid, i_k_obytes_done;

    always #5 i_clk = ~i_clk;

    keccak_stream_host #(.TIMEOUT_CYC(1024)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_msg_len(i_msg_len), .i_out_len(i_out_len),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
        .o_dout_we(o_dout_we), .o_dout_addr(o_dout_addr), .o_dout_data(o_dout_data),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_k_mode(o_k_mode), .o_k_ibytes_len(o_k_ibytes_len), .o_k_obytes_len(o_k_obytes_len),
        .o_k_ibytes(o_k_ibytes), .o_k_ibytes_valid(o_k_ibytes_valid),
        .i_k_ibytes_ready(i_k_ibytes_ready),
        .i_k_obytes(i_k_obytes), .i_k_obytes_valid(i_k_obytes_valid),
        .i_k_obytes_done(i_k_obytes_done)
    );

    int n_tot = 0, n_bad = 0;
    int cyc = 0;
    logic [3:0]  rdy_pat = 4'b1111;
    logic [63:0] mem [256];
    logic [63:0] xw [512];
    logic [6:0]  wa [512];
    logic [63:0] wd [512];
    int n_rd, n_x, n_w, n_done, max_out, n_unstable;
    int t_start, t_rd, t_v, t_err;
    logic seen_v;
    logic [7:0]  rd_addr0;
    logic [1:0]  exp_mode = '0;
    logic [10:0] exp_ilen = '0;
    logic [9:0]  exp_olen = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // source memory: registered read, data one cycle after the strobe
    always @(posedge i_clk) if (o_mem_rd) i_mem_rdata <= mem[o_mem_addr];
    always @(posedge i_clk) cyc++;

    initial forever begin
        @(posedge i_clk);
        #1;
        i_k_ibytes_ready = rdy_pat[cyc % 4];
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (i_start && !o_busy) t_start = cyc;
            if (o_mem_rd) begin
                if (n_rd == 0) begin t_rd = cyc; rd_addr0 = o_mem_addr; end
                n_rd++;
            end
            if (o_k_ibytes_valid && !seen_v) begin t_v = cyc; seen_v = 1'b1; end
            if (o_k_ibytes_valid && i_k_ibytes_ready && n_x < 512) begin
                xw[n_x] = o_k_ibytes;
                n_x++;
            end
            if (n_rd - n_x > max_out) max_out = n_rd - n_x;
            if (o_busy && (o_k_ibytes_len !== exp_ilen || o_k_mode !== exp_mode ||
                           o_k_obytes_len !== exp_olen)) n_unstable++;
            if (o_dout_we && n_w < 512) begin
                wa[n_w] = o_dout_addr;
                wd[n_w] = o_dout_data;
                n_w++;
            end
            if (o_done) n_done++;
        end
    end

    task automatic mon_clr();
        n_rd = 0; n_x = 0; n_w = 0; n_done = 0; max_out = 0; n_unstable = 0;
        seen_v = 1'b0; t_start = 0; t_rd = 0; t_v = 0; rd_addr0 = 8'hFF;
    endtask

    function automatic logic [63:0] exp_word(input int idx, input int mlen);
        logic [63:0] w;
        w = (mlen == 0) ? 64'd0 : mem[idx];
        for (int b = 0; b < 8; b++)
            if (idx * 8 + b >= mlen) w[63 - 8*b -: 8] = 8'h00;
        return w;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_error, 0);
        chk({tag, "_rd"}, o_mem_rd, 0);
        chk({tag, "_raddr"}, o_mem_addr, 0);
        chk({tag, "_we"}, o_dout_we, 0);
        chk({tag, "_waddr"}, o_dout_addr, 0);
        chk({tag, "_wdata"}, o_dout_data, 0);
        chk({tag, "_kmode"}, o_k_mode, 0);
        chk({tag, "_kilen"}, o_k_ibytes_len, 0);
        chk({tag, "_kolen"}, o_k_obytes_len, 0);
        chk({tag, "_kvld"}, o_k_ibytes_valid, 0);
        chk({tag, "_kdat"}, o_k_ibytes, 0);
    endtask

    task automatic run_txn(input string tag, input logic [1:0] mode, input int mlen,
                           input int olen, input int nout, input logic [3:0] pat,
                           input bit dup);
        int n_in, g;
        bit duped;
        n_in = (mlen == 0) ? 1 : (mlen + 7) / 8;
        exp_mode = mode;
        exp_ilen = 11'(mlen);
        exp_olen = (mode == 2'b10) ? 10'd32 : (mode == 2'b11) ? 10'd64 : 10'(olen);
        mon_clr();
        rdy_pat = pat;
        duped = 0;
        @(posedge i_clk); #1;
        i_start = 1; i_mode = mode; i_msg_len = 11'(mlen); i_out_len = 10'(olen);
        @(posedge i_clk); #1;
        i_start = 0;
        chk({tag, "_busy"}, o_busy, 1);
        g = 0;
        while (n_x < n_in && g < 3000) begin
            @(negedge i_clk);
            g++;
            if (dup && !duped && n_x >= 3) begin
                duped = 1;
                i_start = 1; i_mode = 2'b11; i_msg_len = 11'd5;
                @(negedge i_clk);
                i_start = 0;
            end
        end
        chk({tag, "_nxfer"}, n_x, n_in);
        chk({tag, "_nrd"}, n_rd, (mlen == 0) ? 0 : n_in);
        if (mlen != 0) begin
            chk({tag, "_lat_rd"}, t_rd - t_start, 2);
            chk({tag, "_addr0"}, rd_addr0, 0);
        end
        chk({tag, "_lat_v"}, t_v - t_start, (mlen == 0) ? 2 : 3);
        chk({tag, "_occ"}, max_out <= 2, 1);
        for (int k = 0; k < n_in; k++) chk({tag, "_word"}, xw[k], exp_word(k, mlen));
        for (int k = 0; k < nout; k++) begin
            @(posedge i_clk); #1;
            i_k_obytes_valid = 1;
            i_k_obytes = 64'hD0D0_0000_0000_0000 + 64'(k);
            i_k_obytes_done = (k == nout - 1);
        end
        @(posedge i_clk); #1;
        i_k_obytes_valid = 0; i_k_obytes_done = 0;
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_busy_dn"}, o_busy, 1);
        @(posedge i_clk); #1;
        chk({tag, "_done_clr"}, o_done, 0);
        chk({tag, "_idle"}, o_busy, 0);
        chk({tag, "_nwr"}, n_w, nout);
        for (int k = 0; k < nout; k++) begin
            chk({tag, "_waddr"}, wa[k], 64'(k % 128));
            chk({tag, "_wdata"}, wd[k], 64'hD0D0_0000_0000_0000 + 64'(k));
        end
        chk({tag, "_stable"}, n_unstable, 0);
        chk({tag, "_ndone"}, n_done, 1);
    endtask

    initial begin
        int g;
        for (int i = 0; i < 256; i++)
            mem[i] = {8'(i), 8'hA5, 16'(i * 7), 32'hBEEF_0000 | 32'(i)};
        mem[0] = 64'h0011_2233_4455_6677;
        mem[1] = 64'h8899_AABB_CCDD_EEFF;
        i_rst = 1; i_start = 0; i_mode = 0; i_msg_len = 0; i_out_len = 0;
        i_mem_rdata = 0; i_k_ibytes_ready = 1;
        i_k_obytes = 0; i_k_obytes_valid = 0; i_k_obytes_done = 0;
        mon_clr();
        repeat (3) @(posedge i_clk);
        #1;
        chk_zero("rst");
        i_rst = 0;

        run_txn("sha256_empty", 2'b10, 0, 0, 4, 4'b1111, 0);
        chk("sha256_olen", o_k_obytes_len, 32);
        chk("sha256_w0", xw[0], 64'h0);

        run_txn("sha512_13", 2'b11, 13, 0, 8, 4'b1111, 0);
        chk("sha512_x1", xw[1], 64'h8899_AABB_CC00_0000);
        chk("sha512_olen", o_k_obytes_len, 64);

        run_txn("shake128_200", 2'b00, 200, 300, 38, 4'b1111, 1);
        chk("shake128_ilen", o_k_ibytes_len, 200);
        chk("shake128_olen", o_k_obytes_len, 300);

        run_txn("rdy1001", 2'b01, 100, 40, 5, 4'b1001, 0);

        // SHAKE with zero output length: abort pulse, nothing fetched
        mon_clr();
        @(posedge i_clk); #1;
        i_start = 1; i_mode = 2'b00; i_msg_len = 11'd16; i_out_len = 10'd0;
        @(posedge i_clk); #1;
        i_start = 0;
        chk("zlen_err", o_error, 1);
        chk("zlen_busy", o_busy, 1);
        @(posedge i_clk); #1;
        chk("zlen_err_clr", o_error, 0);
        chk("zlen_idle", o_busy, 0);
        repeat (5) @(posedge i_clk);
        #1;
        chk("zlen_nrd", n_rd, 0);
        chk("zlen_olen_kept", o_k_obytes_len, 64'(exp_olen));

        // reset in the middle of a 17-word feed
        exp_mode = 2'b00; exp_ilen = 11'd136; exp_olen = 10'd16;
        mon_clr();
        rdy_pat = 4'b1111;
        @(posedge i_clk); #1;
        i_start = 1; i_mode = 2'b00; i_msg_len = 11'd136; i_out_len = 10'd16;
        @(posedge i_clk); #1;
        i_start = 0;
        g = 0;
        while (n_x < 4 && g < 100) begin @(negedge i_clk); g++; end
        chk("mid_reached", n_x >= 4, 1);
        @(posedge i_clk); #1;
        i_rst = 1;
        @(posedge i_clk); #1;
        chk_zero("mid_rst");
        i_rst = 0;
        run_txn("after_rst", 2'b00, 136, 16, 2, 4'b1111, 0);

`ifdef KECCAK_HOST_TIMEOUT_EN
        exp_mode = 2'b01; exp_ilen = 11'd16; exp_olen = 10'd8;
        mon_clr();
        rdy_pat = 4'b0000;
        @(posedge i_clk); #1;
        i_start = 1; i_mode = 2'b01; i_msg_len = 11'd16; i_out_len = 10'd8;
        @(posedge i_clk); #1;
        i_start = 0;
        g = 0;
        t_err = -1;
        while (t_err < 0 && g < 1500) begin
            @(negedge i_clk);
            g++;
            if (o_error) t_err = cyc;
        end
        chk("to_lat", t_err - t_start, 1026);
        @(posedge i_clk); #1;
        chk("to_idle", o_busy, 0);
        chk("to_nodone", n_done, 0);
        rdy_pat = 4'b1111;
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/keccak_stream_host.md
# keccak_stream_host

Host-side driver for the Keccak sponge core. It fetches a message from a word-addressed source memory and streams it into the core's input-bytes handshake. It then collects the squeezed output words into a destination memory and reports completion to the system controller. It sits between the system command/memory fabric and the sponge core, driving every core input and consuming every core output.

## Interface
- Parameters:
- `TIMEOUT_CYC`, 1024: idle-progress cycles before abort (only with `KECCAK_HOST_TIMEOUT_EN`).
- Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset. **One clock; reset is synchronous and active-high.**
- `i_start` in 1: single-cycle command strobe; ignored while `o_busy`.
- `i_mode` in 2: 00 SHAKE128, 01 SHAKE256, 10 SHA3-256, 11 SHA3-512.
- `i_msg_len` in 11: message length in bytes.
- `i_out_len` in 10: output bytes for the SHAKE modes; ignored for the SHA3 modes.
- `o_mem_rd` out 1: source read strobe.
- `o_mem_addr` out 8: source word address.
- `i_mem_rdata` in 64: read data, valid exactly 1 cycle after `o_mem_rd`.
- `o_dout_we` out 1: destination write strobe.
- `o_dout_addr` out 7: destination word address.
- `o_dout_data` out 64: destination write data.
- `o_busy` out 1: transaction in progress.
- `o_done` out 1: 1-cycle completion pulse.
- `o_error` out 1: 1-cycle abort pulse.
- `o_k_mode` out 2, `o_k_ibytes_len` out 11, `o_k_obytes_len` out 10: core configuration, held stable for the whole transaction.
- `o_k_ibytes` out 64, `o_k_ibytes_valid` out 1, `i_k_ibytes_ready` in 1: core input handshake.
- `i_k_obytes` in 64, `i_k_obytes_valid` in 1, `i_k_obytes_done` in 1: core output stream.

## Operation
- **States:** IDLE → CFG → FEED → DRAIN → IDLE.
- **IDLE:**
  - On `i_start`, latch mode and lengths into the `o_k_*` configuration registers.
  - Compute `n_in = ceil(msg_len/8)` (9 bits, max 256) and go to CFG.
- **CFG:** one cycle. Clear the address, FIFO and word counters, then go to FEED.
- **FEED, prefetch:**
  - A 2-entry prefetch FIFO holds message words.
  - Issue a read when fetched < `n_in` and FIFO occupancy plus in-flight reads < 2.
  - The read address increments by 1 per read.
- **FEED, handshake:**
  - `o_k_ibytes_valid` = FIFO not empty; `o_k_ibytes` = FIFO head.
  - A transfer occurs when valid and `i_k_ibytes_ready` are both high; the FIFO pops on a transfer.
  - After `n_in` transfers, go to DRAIN.
  - Valid stays low after the last transfer.
- **Byte order and masking:**
  - Byte 0 of each word is in [63:56].
  - In the final word, bytes with index ≥ `msg_len mod 8` are forced to zero (no masking when the remainder is 0).
- **Empty message (`msg_len`=0):**
  - No memory read is issued.
  - One all-zero word is presented with `o_k_ibytes_len`=0 and counts as the single transfer.
- **Output length:**
  - `o_k_obytes_len` = `i_out_len` for the SHAKE modes, 32 for SHA3-256, 64 for SHA3-512.
  - `i_out_len`=0 in a SHAKE mode: `o_error` pulses and the block stays in IDLE.
- **DRAIN:**
  - Each `i_k_obytes_valid` cycle registers a write: `o_dout_data`=`i_k_obytes`, `o_dout_we`=1.
  - `o_dout_addr` starts at 0 and increments after each write; the 7-bit address wraps at 128.
  - `i_k_obytes_valid` is also honoured while in FEED.
  - On `i_k_obytes_done`, pulse `o_done` and return to IDLE.
- **Simultaneous events:**
  - Output valid and done in the same cycle: the write is still issued and `o_done` is asserted in the same output cycle.
  - `i_start` while busy is dropped with no side effect.

## Timing
- **Reset values:**
  - 0: all strobes, `o_busy`, `o_done`, `o_error`, addresses, `o_k_*` data/len/mode, FIFO.
- **Reset mid-transaction:** takes effect at the next edge. Valid drops, the FIFO is flushed, in-flight read data is discarded, and the state returns to IDLE.
- **`o_busy`:** high from the cycle after `i_start` until the cycle `o_done` or `o_error` is high, inclusive.
- **Start latency:** `i_start` at cycle T gives CFG at T+1 and the first `o_mem_rd` at T+2. The first `o_k_ibytes_valid` is at T+3 (T+2 for an empty message).
- **Throughput:** sustained 1 word/cycle while ready is held high.
- **Output path:** `o_dout_*` and `o_done` are registered, 1 cycle after the corresponding core signal.
- **Stability:** the `o_k_*` configuration outputs change only in the IDLE→CFG transition.

## Configuration
- **`KECCAK_HOST_TIMEOUT_EN` defined:**
  - A 16-bit counter counts cycles with no input transfer (FEED) and no output word (DRAIN); it resets on progress or state change.
  - Reaching `TIMEOUT_CYC` pulses `o_error`, flushes the FIFO, drops valid and returns to IDLE without `o_done`.
- **Not defined:** no counter; the block waits indefinitely.

## Test plan
- SHA3-256, `msg_len`=0 → one zero word sent with `o_k_ibytes_len`=0; 4 writes at addresses 0..3; `o_done` 1 cycle after `i_k_obytes_done`.
- SHA3-512, `msg_len`=13, memory words 0x0011..77, 0x8899AABBCCDDEEFF → second transfer 0x8899AABBCC000000; `o_k_obytes_len`=64; 8 writes.
- SHAKE128, `msg_len`=200, `i_out_len`=300 → 25 transfers in order; 38 writes; `o_k_ibytes_len` held at 200 throughout.
- Ready toggled 1,0,0,1 under load → no word lost or duplicated; FIFO occupancy never exceeds 2; `o_mem_rd` stalls while the FIFO is full.
- Reset asserted mid-FEED on transfer 5 of 17 → next cycle all outputs are 0; a new `i_start` then runs cleanly from address 0.
- `KECCAK_HOST_TIMEOUT_EN`, `TIMEOUT_CYC`=1024, ready held 0 → `o_error` at cycle 1024 of the stall and no `o_done`; `i_start` during busy is ignored.
